btb_update_unit: RTL

//  Write-side companion of the BTB. Records every fetch-stage BTB prediction in an in-order queue.
//  In Execute it retires the oldest entry against the resolved branch outcome.
//  On a mispredict it raises a one-cycle flush with the redirect PC.
//  It also issues a valid/ready BTB write (insert or invalidate) so the BTB learns the outcome.

---
 rtl/btb_update_unit_pkg.sv | 25 ++
 rtl/btb_update_unit_pred_fifo.sv | 55 +++++
 rtl/btb_update_unit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/btb_update_unit_pkg.sv
// Shared definitions for the BTB update unit: default widths, update
// opcodes, retire-compare result codes and the prediction record layout.
package btb_update_unit_pkg;

  localparam int W_PC_DEF   = 8;
  localparam int W_BTA_DEF  = 32;
  localparam int DEPTH_DEF  = 4;
  localparam int W_PC_FULL  = 32;

  localparam logic UPD_INSERT = 1'b1;
  localparam logic UPD_INVAL  = 1'b0;

  // Outcome of comparing the queue head with the resolved branch
  typedef enum logic [1:0] {
    RES_OK     = 2'd0,
    RES_INSERT = 2'd1,
    RES_INVAL  = 2'd2
  } res_e;

  // Record is packed as {pc, hit, bta}; bta sits in the low bits
  function automatic int rec_w(input int w_bta);
    return W_PC_FULL + 1 + w_bta;
  endfunction

endpackage

// File: rtl/btb_update_unit_pred_fifo.sv
// In-order queue of fetch-stage predictions. Clear has priority over
// push/pop so a mispredict can discard every wrong-path record at once.
module btb_update_unit_pred_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [W-1:0]  r_mem [DEPTH];

  // Storage array; no reset needed because count gates every read
  always_ff @(posedge clk) begin
    if (push && !clear) r_mem[r_wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign full  = (r_count == (AW+1)'(DEPTH));
  assign empty = (r_count == '0);

endmodule

// File: rtl/btb_update_unit.sv
// Write-side companion of the BTB: queues predictions, retires them against
// resolved branches, flushes/redirects on mispredict and teaches the BTB.
module btb_update_unit
  import btb_update_unit_pkg::*;
#(
  parameter int W_PC  = W_PC_DEF,
  parameter int W_BTA = W_BTA_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             f_valid,
  input  logic [31:0]      f_pc,
  input  logic             f_hit,
  input  logic [W_BTA-1:0] f_bta,
  input  logic             e_valid,
  input  logic             e_is_branch,
  input  logic             e_taken,
  input  logic [W_BTA-1:0] e_target,
  output logic             stall_f,
  output logic             flush_o,
  output logic [31:0]      redirect_pc,
  output logic             upd_valid,
  input  logic             upd_ready,
  output logic             upd_insert,
  output logic [W_PC-1:0]  upd_tag,
  output logic [W_BTA-1:0] upd_bta,
  output logic             underflow,
  output logic [15:0]      mispred_cnt
);

  localparam int REC_W   = rec_w(W_BTA);
  localparam int HIT_BIT = W_BTA;
  localparam int PC_LSB  = W_BTA + 1;

  logic [REC_W-1:0] w_head;
  logic [31:0]      w_head_pc;
  logic             w_head_hit;
  logic [W_BTA-1:0] w_head_bta;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic             w_mis;
  res_e             w_res;
  logic [31:0]      w_redir;

  assign w_head_pc  = w_head[PC_LSB +: 32];
  assign w_head_hit = w_head[HIT_BIT];
  assign w_head_bta = w_head[W_BTA-1:0];

  assign w_pop   = e_valid & ~w_empty;
  assign w_mis   = w_pop & (w_res != RES_OK);
  assign w_push  = f_valid & (~w_full | w_pop) & ~w_mis;
  assign stall_f = w_full & ~e_valid;

  btb_update_unit_pred_fifo #(
    .W     (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .pop     (w_pop),
    .clear   (w_mis),
    .din     ({f_pc, f_hit, f_bta}),
    .head    (w_head),
    .full    (w_full),
    .empty   (w_empty)
  );

  // Classify the head record against the resolved outcome (first match wins)
  always_comb begin
    w_res   = RES_OK;
    w_redir = '0;
    if (e_taken && !w_head_hit) begin
      w_res   = RES_INSERT;
      w_redir = 32'(e_target);
    end else if (e_taken && w_head_hit && (w_head_bta != e_target)) begin
      w_res   = RES_INSERT;
      w_redir = 32'(e_target);
    end else if (!e_taken && w_head_hit && e_is_branch) begin
      w_res   = RES_INVAL;
      w_redir = w_head_pc + 32'd4;
    end else if (!e_is_branch && w_head_hit) begin
      w_res   = RES_INVAL;
      w_redir = w_head_pc + 32'd4;
    end
  end

  // One-cycle flush/redirect and underflow pulses, registered off the pop edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flush_o     <= 1'b0;
      redirect_pc <= '0;
      underflow   <= 1'b0;
    end else begin
      flush_o   <= w_mis;
      underflow <= e_valid & w_empty;
      if (w_mis) redirect_pc <= w_redir;
    end
  end

  // Single holding register for BTB writes; a newer mispredict overwrites it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      upd_valid  <= 1'b0;
      upd_insert <= 1'b0;
      upd_tag    <= '0;
      upd_bta    <= '0;
    end else if (w_mis) begin
      upd_valid  <= 1'b1;
      upd_insert <= (w_res == RES_INSERT) ? UPD_INSERT : UPD_INVAL;
      upd_tag    <= w_head_pc[W_PC-1:0];
      upd_bta    <= (w_res == RES_INSERT) ? e_target : '0;
    end else if (upd_valid && upd_ready) begin
      upd_valid <= 1'b0;
    end
  end

  // Saturating mispredict counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mispred_cnt <= '0;
    end else if (w_mis && (mispred_cnt != 16'hFFFF)) begin
      mispred_cnt <= mispred_cnt + 16'd1;
    end
  end

endmodule
